// File: rtl/spawn_pkg.sv
// Shared types and constants for the spawn scheduler and its round-robin arbiter.
package spawn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } spawn_state_t;

    localparam int REQ_CARS    = 0;
    localparam int REQ_FUEL    = 1;
    localparam int REQ_SPECIAL = 2;
    localparam int REQ_TRUCK   = 3;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting bit at or above ptr, else lowest overall.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    logic [N-1:0] hi_mask_s;
    logic [N-1:0] masked_s;
    logic [N-1:0] pool_s;

    // Prefer requests at or above the pointer; lowest-set-bit isolation picks the winner
    always_comb begin
        hi_mask_s = ~((N'(1) << ptr) - N'(1));
        masked_s  = req & hi_mask_s;
        pool_s    = (|masked_s) ? masked_s : req;
        grant     = pool_s & (~pool_s + N'(1));
        valid     = |req;
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: at most one spawn per frame onto a pseudo-randomly chosen cooled-down lane.
// Build option SPAWN_DIFFICULTY_EN shrinks the inter-spawn gap by one frame every 16 grants.
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int         NUM_REQ       = 4,
    parameter int         NUM_LANES     = 4,
    parameter int         LANE_COOLDOWN = 20,
    parameter int         MIN_GAP       = 8,
    parameter int         SPECIAL_IDX   = REQ_SPECIAL,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         gameSeq,
    input  logic                         special,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         spawnValid,
    output logic [$clog2(NUM_LANES)-1:0] spawnLane,
    output logic                         busy
);

    localparam int LW       = $clog2(NUM_LANES);
    localparam int PW       = $clog2(NUM_REQ);
    localparam int CNT_BASE = (LANE_COOLDOWN > MIN_GAP) ? LANE_COOLDOWN : MIN_GAP;
`ifdef SPAWN_DIFFICULTY_EN
    localparam int CNT_MAX  = (CNT_BASE > 255) ? CNT_BASE : 255;
`else
    localparam int CNT_MAX  = CNT_BASE;
`endif
    localparam int CW       = $clog2(CNT_MAX + 1);

    spawn_state_t       state_q, state_d;
    logic [CW-1:0]      gap_q, gap_d;
    logic [CW-1:0]      cool_q [NUM_LANES];
    logic [CW-1:0]      cool_d [NUM_LANES];
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [NUM_REQ-1:0] win_q, win_d;
    logic [LW-1:0]      lane_q, lane_d;

    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] arb_grant_s;
    logic               arb_valid_s;
    logic               lane_ok_s;
    logic               grant_fire_s;
    logic [LW-1:0]      lane_s;
    logic [LW-1:0]      cand_s;
    logic [PW-1:0]      win_idx_s;
    logic [CW-1:0]      gap_reload_s;

    assign elig_s       = req & ~(special ? (NUM_REQ'(1) << SPECIAL_IDX) : '0);
    assign grant_fire_s = (state_q == GRANT) && gameSeq;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (elig_s),
        .ptr   (ptr_q),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    // Lane scan: first lane with zero cooldown, upward from the LFSR low bits with wrap
    always_comb begin
        lane_s    = '0;
        lane_ok_s = 1'b0;
        cand_s    = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cand_s    = lfsr_q[LW-1:0] + LW'(i);
            lane_s    = (cool_q[cand_s] == '0) ? cand_s : lane_s;
            lane_ok_s = lane_ok_s | (cool_q[cand_s] == '0);
        end
    end

    // Encode the registered one-hot winner for the pointer update
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s = win_q[i] ? PW'(i) : win_idx_s;
        end
    end

`ifdef SPAWN_DIFFICULTY_EN
    logic [CW-1:0] gap_reload_q, gap_reload_d;
    logic [3:0]    grant_cnt_q, grant_cnt_d;

    // The 16th grant of each block still loads the old gap; the next block uses one less
    always_comb begin
        gap_reload_d = gap_reload_q;
        grant_cnt_d  = grant_cnt_q;
        if (!gameSeq) begin
            gap_reload_d = CW'(MIN_GAP);
            grant_cnt_d  = 4'd0;
        end else if (grant_fire_s) begin
            grant_cnt_d  = grant_cnt_q + 4'd1;
            gap_reload_d = ((grant_cnt_q == 4'd15) && (gap_reload_q > CW'(2))) ?
                           gap_reload_q - CW'(1) : gap_reload_q;
        end else begin
            grant_cnt_d  = grant_cnt_q;
        end
    end

    // Difficulty registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_reload_q <= CW'(MIN_GAP);
            grant_cnt_q  <= 4'd0;
        end else begin
            gap_reload_q <= gap_reload_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign gap_reload_s = gap_reload_q;
`else
    assign gap_reload_s = CW'(MIN_GAP);
`endif

    // FSM next state, per-frame countdowns and GRANT-cycle reloads (reload wins over decrement)
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cool_d  = cool_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        lane_d  = lane_q;
        lfsr_d  = lfsr_next(lfsr_q);
        if (!gameSeq) begin
            state_d = IDLE;
            gap_d   = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cool_d[i] = '0;
            end
        end else begin
            gap_d = (startOfFrame && (gap_q != '0)) ? gap_q - CW'(1) : gap_q;
            for (int i = 0; i < NUM_LANES; i++) begin
                cool_d[i] = (startOfFrame && (cool_q[i] != '0)) ? cool_q[i] - CW'(1) : cool_q[i];
            end
            case (state_q)
                IDLE: begin
                    state_d = (startOfFrame && (gap_q == '0) && (|elig_s)) ? ARB : IDLE;
                end
                ARB: begin
                    state_d = (arb_valid_s && lane_ok_s) ? GRANT : IDLE;
                    win_d   = arb_grant_s;
                    lane_d  = lane_s;
                end
                GRANT: begin
                    state_d        = IDLE;
                    cool_d[lane_q] = CW'(LANE_COOLDOWN);
                    gap_d          = gap_reload_s;
                    ptr_d          = (win_idx_s == PW'(NUM_REQ - 1)) ? '0 : win_idx_s + PW'(1);
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
            cool_q  <= '{default: '0};
            ptr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            win_q   <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cool_q  <= cool_d;
            ptr_q   <= ptr_d;
            lfsr_q  <= lfsr_d;
            win_q   <= win_d;
            lane_q  <= lane_d;
        end
    end

    assign grant      = (grant_fire_s && !reset) ? win_q : '0;
    assign spawnValid = grant_fire_s && !reset;
    assign spawnLane  = (grant_fire_s && !reset) ? lane_q : '0;
    assign busy       = (state_q != IDLE) && !reset;

endmodule
